// File: rtl/conv_frame_gen.sv
// Stimulus source: LFSR-generated information frames, rate-1/2 convolutionally encoded,
// handed out one frame at a time on a valid/ready interface.
module conv_frame_gen #(
   parameter int unsigned  FRAME_BITS = 8,
   parameter int unsigned  K          = 3,
   parameter logic [K-1:0] G0         = 3'b111,
   parameter logic [K-1:0] G1         = 3'b101,
   parameter int unsigned  TAIL       = 1,
   parameter logic [15:0]  LFSR_SEED  = 16'hACE1,
   localparam int unsigned NSYM       = FRAME_BITS + TAIL * (K - 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [FRAME_BITS-1:0] info_word,
   output logic [2*NSYM-1:0]     enc_word,
   output logic [15:0]           frame_cnt
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StShift = 3'd2;
   localparam logic [2:0] StTail  = 3'd3;
   localparam logic [2:0] StHold  = 3'd4;

   localparam logic [4:0] LastInfo = 5'(FRAME_BITS - 1);
   localparam logic [4:0] LastSym  = 5'(NSYM - 1);

   logic [2:0]            state_q, state_d;
   logic [15:0]           lfsr_q, lfsr_next;
   logic [K-2:0]          sr_q;
   logic [4:0]            idx_q;
   logic [FRAME_BITS-1:0] info_q, info_sh;
   logic [2*NSYM-1:0]     enc_q, enc_d;
   logic [15:0]           cnt_q;
   logic                  valid_q;
   logic                  in_bit, c0, c1;
   logic [K-1:0]          u;

   assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   // Tail symbols are encoded with a zero input bit.
   always_comb begin
      info_sh = info_q >> idx_q;
      in_bit  = 1'b0;
      if (state_q == StShift) in_bit = info_sh[0];
      u  = {in_bit, sr_q};
      c0 = ^(u & G0);
      c1 = ^(u & G1);
      enc_d = enc_q;
      for (int i = 0; i < int'(NSYM); i++) begin
         if (idx_q == 5'(i)) enc_d[2*i +: 2] = {c1, c0};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (en) state_d = StLoad;
         StLoad:  state_d = StShift;
         StShift: begin
            if (idx_q == LastInfo) state_d = (TAIL != 0) ? StTail : StHold;
         end
         StTail:  if (idx_q == LastSym) state_d = StHold;
         StHold:  if (out_ready) state_d = en ? StLoad : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         lfsr_q  <= LFSR_SEED;
         sr_q    <= '0;
         idx_q   <= '0;
         info_q  <= '0;
         enc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d == StHold);
         case (state_q)
            StLoad: begin
               info_q <= lfsr_q[FRAME_BITS-1:0];
               lfsr_q <= lfsr_next;
               if (TAIL != 0) sr_q <= '0;
               idx_q  <= '0;
            end
            StShift, StTail: begin
               enc_q <= enc_d;
               sr_q  <= {in_bit, sr_q[K-2:1]};
               idx_q <= idx_q + 5'd1;
            end
            StHold: begin
               if (out_ready) cnt_q <= cnt_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = valid_q;
   assign info_word = info_q;
   assign enc_word  = enc_q;
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_conv_frame_gen.sv
// Directed bench for conv_frame_gen: default, continuous-stream and K=7 configurations.
module tb_conv_frame_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        def_en, def_rdy, def_valid;
   logic [7:0]  def_info;
   logic [19:0] def_enc;
   logic [15:0] def_cnt;
   logic        nt_en, nt_rdy, nt_valid;
   logic [3:0]  nt_info;
   logic [7:0]  nt_enc;
   logic [15:0] nt_cnt;
   logic        k7_en, k7_rdy, k7_valid;
   logic [15:0] k7_info;
   logic [43:0] k7_enc;
   logic [15:0] k7_cnt;

   conv_frame_gen u_def (
      .clk(clk), .rst(rst), .en(def_en), .out_ready(def_rdy), .out_valid(def_valid),
      .info_word(def_info), .enc_word(def_enc), .frame_cnt(def_cnt)
   );

   conv_frame_gen #(.FRAME_BITS(4), .TAIL(0)) u_nt (
      .clk(clk), .rst(rst), .en(nt_en), .out_ready(nt_rdy), .out_valid(nt_valid),
      .info_word(nt_info), .enc_word(nt_enc), .frame_cnt(nt_cnt)
   );

   conv_frame_gen #(.FRAME_BITS(16), .K(7), .G0(7'o171), .G1(7'o133)) u_k7 (
      .clk(clk), .rst(rst), .en(k7_en), .out_ready(k7_rdy), .out_valid(k7_valid),
      .info_word(k7_info), .enc_word(k7_enc), .frame_cnt(k7_cnt)
   );

   int n_run  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic vsel(input int which);
      case (which)
         0:       return def_valid;
         1:       return nt_valid;
         default: return k7_valid;
      endcase
   endfunction

   task automatic wait_valid(input int which, input int budget, output int n);
      n = 0;
      while (!vsel(which) && n < budget) begin
         tick();
         n++;
      end
      if (!vsel(which)) check("valid_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Reference encoder: window holds the current bit at [6] and older bits below it.
   function automatic logic [43:0] enc_k7(input logic [15:0] info);
      logic [6:0]  win;
      logic [43:0] out;
      logic        b;
      win = '0;
      out = '0;
      for (int i = 0; i < 22; i++) begin
         b   = (i < 16) ? info[i] : 1'b0;
         win = {b, win[6:1]};
         out[2*i]   = ^(win & 7'o171);
         out[2*i+1] = ^(win & 7'o133);
      end
      return out;
   endfunction

   logic [3:0]  nt_info_tab [4] = '{4'h1, 4'h0, 4'h8, 4'hC};
   logic [7:0]  nt_enc_tab  [4] = '{8'h37, 8'h00, 8'hC0, 8'hBD};

   initial begin
      int n, seen;
      logic [15:0] model;
      rst = 1'b1;
      def_en = 0; def_rdy = 0; nt_en = 0; nt_rdy = 0; k7_en = 0; k7_rdy = 0;
      tick(); tick();
      rst = 1'b0;
      check("rst_valid", 64'(def_valid), 64'd0);
      check("rst_info", 64'(def_info), 64'd0);
      check("rst_enc", 64'(def_enc), 64'd0);
      check("rst_cnt", 64'(def_cnt), 64'd0);

      // First frame, held off by ready for 20 cycles.
      def_en = 1'b1;
      tick();
      check("load_valid", 64'(def_valid), 64'd0);
      wait_valid(0, 40, n);
      check("first_latency", 64'(n), 64'd11);
      check("f1_info", 64'(def_info), 64'hE1);
      check("f1_enc", 64'(def_enc), 64'hE6C37);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_valid", 64'(def_valid), 64'd1);
         check("stall_enc", 64'(def_enc), 64'hE6C37);
         check("stall_cnt", 64'(def_cnt), 64'd0);
      end
      def_rdy = 1'b1;
      tick();
      def_rdy = 1'b0;
      check("xfer_cnt", 64'(def_cnt), 64'd1);
      check("xfer_valid", 64'(def_valid), 64'd0);
      wait_valid(0, 40, n);
      check("f2_info", 64'(def_info), 64'h70);
      check("f2_enc", 64'(def_enc), 64'h39B00);

      // Back-to-back period with ready held high.
      def_rdy = 1'b1;
      tick();
      wait_valid(0, 40, n);
      check("period", 64'(n + 1), 64'd12);
      check("f3_info", 64'(def_info), 64'h38);
      check("f3_cnt", 64'(def_cnt), 64'd2);

      // Reset in the middle of a frame.
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", 64'(def_valid), 64'd0);
      check("midrst_cnt", 64'(def_cnt), 64'd0);
      check("midrst_info", 64'(def_info), 64'd0);
      wait_valid(0, 40, n);
      check("rst_f1_info", 64'(def_info), 64'hE1);
      check("rst_f1_enc", 64'(def_enc), 64'hE6C37);

      // Dropping en mid-frame lets the frame finish, then the block idles.
      tick();
      tick();
      def_en = 1'b0;
      wait_valid(0, 40, n);
      check("en_off_info", 64'(def_info), 64'h70);
      check("en_off_enc", 64'(def_enc), 64'h39B00);
      tick();
      check("en_off_cnt", 64'(def_cnt), 64'd2);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (def_valid) seen++;
      end
      check("idle_no_valid", 64'(seen), 64'd0);
      def_en = 1'b1;
      wait_valid(0, 40, n);
      check("resume_info", 64'(def_info), 64'h38);
      def_en = 1'b0;

      // Continuous stream: encoder state carries across frame boundaries.
      nt_en = 1'b1;
      nt_rdy = 1'b1;
      for (int f = 0; f < 4; f++) begin
         wait_valid(1, 20, n);
         check("nt_info", 64'(nt_info), 64'(nt_info_tab[f]));
         check("nt_enc", 64'(nt_enc), 64'(nt_enc_tab[f]));
         tick();
      end
      nt_en = 1'b0;
      check("nt_cnt", 64'(nt_cnt), 64'd4);

      // K=7 against the reference encoder.
      k7_en = 1'b1;
      k7_rdy = 1'b1;
      model = 16'hACE1;
      for (int f = 0; f < 1000; f++) begin
         wait_valid(2, 60, n);
         if (!k7_valid) break;
         check("k7_info", 64'(k7_info), 64'(model));
         check("k7_enc", 64'(k7_enc), 64'(enc_k7(model)));
         model = lfsr_step(model);
         tick();
      end
      k7_en = 1'b0;
      check("k7_cnt", 64'(k7_cnt), 64'd1000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_frame_gen.md
Name: conv_frame_gen

Overview:
- Parametrised successor to the serial-source/encoder/paralleler stimulus chain.
- Generates pseudo-random information frames from an internal Galois LFSR, which makes the stream deterministic and reproducible.
- Convolutionally encodes each frame at rate 1/2 with programmable constraint length and generator polynomials, with optional zero-tail termination.
- Presents the packed codeword plus source bits on a valid/ready interface. Feeds the Viterbi decoder bench and its scoreboard.

Parameters:
- FRAME_BITS, 8: information bits per frame, 1..16.
- K, 3: constraint length, 3..7.
- G0, 3'b111: generator polynomial for output c0, K bits. MSB taps the current input bit.
- G1, 3'b101: generator polynomial for output c1, K bits.
- TAIL, 1: 1 = append K-1 zero tail bits and restart encoder state each frame; 0 = continuous stream.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- Derived: NSYM = FRAME_BITS + TAIL*(K-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  enable frame generation
- out_ready  in  1  sink accepts frame
- out_valid  out  1  frame available
- info_word  out  FRAME_BITS  source bits of the frame, bit 0 encoded first
- enc_word  out  2*NSYM  codeword; symbol i = {c1,c0} at bits [2i+1:2i]
- frame_cnt  out  16  frames accepted since reset

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, lfsr=LFSR_SEED, encoder shift register sr[K-2:0]=0, out_valid=0, info_word=0, enc_word=0, frame_cnt=0. Reset wins over every other event, including mid-frame and during HOLD; any partial frame is discarded.
- State IDLE: go to LOAD when en=1.
- State LOAD (1 cycle):
  - info_word <= lfsr[FRAME_BITS-1:0].
  - lfsr advances one step: Galois right shift; if the old lsb is 1, XOR the result with 16'hB400.
  - If TAIL=1, sr <= 0.
  - Bit index <= 0. Go to SHIFT.
- State SHIFT (FRAME_BITS cycles):
  - Input bit b = info_word[idx]; u = {b, sr}, a K-bit vector.
  - c0 = XOR-reduce(u & G0); c1 = XOR-reduce(u & G1).
  - Write enc_word[2*idx] <= c0 and enc_word[2*idx+1] <= c1.
  - sr <= {b, sr[K-2:1]}.
  - After the last bit, go to TAIL if TAIL=1, else HOLD.
- State TAIL (K-1 cycles): same as SHIFT with b=0, writing symbols FRAME_BITS..NSYM-1. Go to HOLD.
- State HOLD:
  - out_valid=1; info_word and enc_word are stable.
  - On out_valid & out_ready: out_valid <= 0 and frame_cnt++ (16-bit wrap, 16'hFFFF -> 0). Next state is LOAD if en=1, else IDLE.
  - Without ready the block stalls indefinitely; the LFSR does not advance.
- out_valid is registered and is 0 in all states except HOLD.
- Frame period with out_ready held at 1: NSYM + 2 cycles (10+2 = 12 cycles at defaults).
- en is sampled only in IDLE and on the HOLD transfer cycle. Deasserting en mid-frame does not abort the frame.
- TAIL=0: sr carries across frames and is cleared only by rst, so enc_word is the exact slice of one continuous encoded stream.

Test Plan:
- Defaults, en=1, out_ready=1 after reset → first frame: info_word=8'hE1, enc_word=20'hE6C37. out_valid first rises 11 cycles after the LOAD entry cycle. Second frame: info_word=8'h70.
- out_ready=0 for 20 cycles during the first HOLD → out_valid stays 1, enc_word stays 20'hE6C37, frame_cnt stays 0. Ready for 1 cycle → frame_cnt=1, second frame info is 8'h70 (no LFSR skip).
- TAIL=0, FRAME_BITS=4, two frames → concatenated enc_word symbols match a golden model encoding the 8-bit stream without state reset. Frame 2 symbol 0 depends on frame 1's last two bits.
- Assert rst mid-SHIFT of frame 3 → next cycle out_valid=0 and frame_cnt=0. The following frame again gives info_word=8'hE1 and enc_word=20'hE6C37.
- Deassert en during SHIFT → the frame completes and transfers, then the block goes to IDLE with no further out_valid. Re-assert en → generation resumes with the next LFSR value.
- K=7, G0=7'o171, G1=7'o133, FRAME_BITS=16 → 1000 frames match the golden model. enc_word width is 44. frame_cnt=1000.
